// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter and the line filter it
// shares with the mouse receiver.
package ps2_pkg;

  // Host-to-device transfer sequence
  typedef enum logic [3:0] {
    IDLE,
    INHIBIT,
    RTS,
    WAIT_CLK,
    SHIFT,
    ACK,
    WAIT_IDLE,
    DONE,
    ERR
  } ps2_tx_state_t;

  // Failure reasons reported on tx_err_code
  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_START = 2'b01;
  localparam logic [1:0] ERR_XFER  = 2'b10;
  localparam logic [1:0] ERR_NOACK = 2'b11;

  // Mouse commands
  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;

  // PS/2 frames carry odd parity over the eight data bits
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes the raw ps2clk/ps2data pins, debounces ps2clk and produces a
// one-cycle strobe on each accepted falling clock edge.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic sysClk,
  input  logic iRst_n,
  input  logic clk_raw,
  input  logic data_raw,
  output logic clk_filt,
  output logic data_sync,
  output logic fall
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FCW-1:0] RUN_LIM = FCW'(FILTER_LEN - 1);

  logic [1:0]     clk_sync;
  logic [1:0]     data_sync_q;
  logic [FCW-1:0] run_cnt;

  // Two-flop synchronizers; idle PS/2 lines are high, so reset to 1
  always_ff @(posedge sysClk or negedge iRst_n) begin
    if (!iRst_n) begin
      clk_sync    <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync    <= {clk_sync[0], clk_raw};
      data_sync_q <= {data_sync_q[0], data_raw};
    end
  end

  // Accept a new clock level only after FILTER_LEN consecutive differing samples
  always_ff @(posedge sysClk or negedge iRst_n) begin
    if (!iRst_n) begin
      clk_filt <= 1'b1;
      run_cnt  <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_sync[1] == clk_filt) begin
        run_cnt <= '0;
      end else if (run_cnt == RUN_LIM) begin
        clk_filt <= clk_sync[1];
        run_cnt  <= '0;
        fall     <= clk_filt & ~clk_sync[1];
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end

  assign data_sync = data_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to the mouse by
// pulling the open-drain lines low through ps2clk_oe/ps2data_oe.
//
// Handshake: a command is taken on any cycle where tx_valid and tx_ready are
// both high. tx_ready is high only in IDLE, so a request presented while busy
// is not taken and not queued; the requester must hold tx_valid until ready.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int START_TIMEOUT  = 1500000,
  parameter int XFER_TIMEOUT   = 200000,
  parameter int FILTER_LEN     = 8
) (
  input  logic          sysClk,
  input  logic          iRst_n,
  input  logic          tx_valid,
  input  logic [7:0]    tx_data,
  output logic          tx_ready,
  output logic          busy,
  output logic          tx_done,
  output logic          tx_err,
  output logic [1:0]    tx_err_code,
  input  logic          ps2clk_in,
  input  logic          ps2data_in,
  output logic          ps2clk_oe,
  output logic          ps2data_oe,
  output ps2_tx_state_t dbg_state
);

  // One counter width covers every interval; it also fits XFER_TIMEOUT so a
  // larger transfer budget can never be cut short by saturation.
  localparam int MAX_AB  = (START_TIMEOUT > INHIBIT_CYCLES) ? START_TIMEOUT : INHIBIT_CYCLES;
  localparam int MAX_CNT = (XFER_TIMEOUT > MAX_AB) ? XFER_TIMEOUT : MAX_AB;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] INH_LIM   = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] START_LIM = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] XFER_LIM  = CW'(XFER_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_SAT   = {CW{1'b1}};

  ps2_tx_state_t state, state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] xfer_cnt;
  logic [3:0]    bitcnt;
  logic [8:0]    frame;
  logic          data_oe_q;
  logic [1:0]    err_code_q;
  logic          err_load;
  logic [1:0]    err_val;
  logic          clk_filt;
  logic          data_sync;
  logic          fall;
  logic          start_to;
  logic          xfer_to;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .sysClk   (sysClk),
    .iRst_n   (iRst_n),
    .clk_raw  (ps2clk_in),
    .data_raw (ps2data_in),
    .clk_filt (clk_filt),
    .data_sync(data_sync),
    .fall     (fall)
  );

  // cnt runs from the RTS cycle, so START_TIMEOUT is measured from RTS;
  // xfer_cnt runs from the first device falling edge.
  assign start_to = (cnt >= START_LIM);
  assign xfer_to  = (xfer_cnt >= XFER_LIM);

  // State register
  always_ff @(posedge sysClk or negedge iRst_n) begin
    if (!iRst_n) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state and per-state outputs; timeouts are checked before fall
  always_comb begin
    state_next = state;
    tx_ready   = 1'b0;
    busy       = 1'b1;
    tx_done    = 1'b0;
    tx_err     = 1'b0;
    ps2clk_oe  = 1'b0;
    err_load   = 1'b0;
    err_val    = ERR_NONE;
    case (state)
      IDLE: begin
        tx_ready = 1'b1;
        busy     = 1'b0;
        if (tx_valid) state_next = INHIBIT;
      end
      INHIBIT: begin
        ps2clk_oe = 1'b1;
        if (cnt >= INH_LIM) state_next = RTS;
      end
      RTS: begin
        ps2clk_oe  = 1'b1;
        state_next = WAIT_CLK;
      end
      WAIT_CLK: begin
        if (start_to) begin
          state_next = ERR;
          err_load   = 1'b1;
          err_val    = ERR_START;
        end else if (fall) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (xfer_to) begin
          state_next = ERR;
          err_load   = 1'b1;
          err_val    = ERR_XFER;
        end else if (fall && bitcnt == 4'd9) begin
          state_next = ACK;
        end
      end
      ACK: begin
        if (xfer_to) begin
          state_next = ERR;
          err_load   = 1'b1;
          err_val    = ERR_XFER;
        end else if (fall) begin
          if (!data_sync) begin
            state_next = WAIT_IDLE;
          end else begin
            state_next = ERR;
            err_load   = 1'b1;
            err_val    = ERR_NOACK;
          end
        end
      end
      WAIT_IDLE: begin
        if (xfer_to) begin
          state_next = ERR;
          err_load   = 1'b1;
          err_val    = ERR_XFER;
        end else if (clk_filt && data_sync) begin
          state_next = DONE;
        end
      end
      DONE: begin
        tx_done    = 1'b1;
        state_next = IDLE;
      end
      ERR: begin
        tx_err     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Frame, counters and data line; data only changes the cycle after a fall
  always_ff @(posedge sysClk or negedge iRst_n) begin
    if (!iRst_n) begin
      cnt        <= '0;
      xfer_cnt   <= '0;
      bitcnt     <= '0;
      frame      <= '0;
      data_oe_q  <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (tx_valid) begin
            frame      <= {odd_parity(tx_data), tx_data};
            cnt        <= '0;
            xfer_cnt   <= '0;
            bitcnt     <= '0;
            err_code_q <= ERR_NONE;
            data_oe_q  <= 1'b0;
          end
        end
        INHIBIT: begin
          if (state_next == RTS) begin
            cnt       <= '0;
            data_oe_q <= 1'b1;
          end else begin
            cnt <= (cnt == CNT_SAT) ? cnt : cnt + 1'b1;
          end
        end
        RTS: cnt <= (cnt == CNT_SAT) ? cnt : cnt + 1'b1;
        WAIT_CLK: begin
          cnt <= (cnt == CNT_SAT) ? cnt : cnt + 1'b1;
          if (state_next == SHIFT) begin
            data_oe_q <= ~frame[0];
            bitcnt    <= 4'd1;
            xfer_cnt  <= CW'(1);
          end
        end
        SHIFT: begin
          xfer_cnt <= (xfer_cnt == CNT_SAT) ? xfer_cnt : xfer_cnt + 1'b1;
          if (fall && !xfer_to) begin
            if (bitcnt == 4'd9) data_oe_q <= 1'b0;
            else                data_oe_q <= ~frame[bitcnt];
            bitcnt <= bitcnt + 4'd1;
          end
        end
        ACK, WAIT_IDLE: xfer_cnt <= (xfer_cnt == CNT_SAT) ? xfer_cnt : xfer_cnt + 1'b1;
        default: ;
      endcase
      if (err_load) begin
        err_code_q <= err_val;
        data_oe_q  <= 1'b0;
      end
    end
  end

  assign ps2data_oe  = data_oe_q;
  assign tx_err_code = err_code_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx with a behavioural PS/2 device on the shared lines.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 200;
  localparam int ST   = 3000;
  localparam int XF   = 4000;
  localparam int FL   = 8;
  localparam int HALF = 40;

  logic sysClk = 1'b0;
  logic iRst_n = 1'b0;
  logic tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_ready, busy, tx_done, tx_err;
  logic [1:0] tx_err_code;
  logic ps2clk_in, ps2data_in, ps2clk_oe, ps2data_oe;
  ps2_tx_state_t dbg_state;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  logic [9:0] exp_q[$];
  logic [3:0] res_q[$];
  logic [3:0] act_q[$];
  int         act_t_q[$];

  // Clock/reset block
  always #5 sysClk = ~sysClk;
  always @(posedge sysClk) cyc <= cyc + 1;

  // Open-drain lines: low when either side pulls
  assign ps2clk_in  = ~(ps2clk_oe | dev_clk_low);
  assign ps2data_in = ~(ps2data_oe | dev_data_low);

  // Result monitor: {tx_done, tx_err, tx_err_code} plus the cycle it appeared
  always @(posedge sysClk) begin
    if (tx_done || tx_err) begin
      act_q.push_back({tx_done, tx_err, tx_err_code});
      act_t_q.push_back(cyc);
      if (tx_done) done_cnt <= done_cnt + 1;
      if (tx_err)  err_cnt  <= err_cnt + 1;
    end
  end

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_TIMEOUT (ST),
    .XFER_TIMEOUT  (XF),
    .FILTER_LEN    (FL)
  ) dut (
    .sysClk     (sysClk),
    .iRst_n     (iRst_n),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .tx_err_code(tx_err_code),
    .ps2clk_in  (ps2clk_in),
    .ps2data_in (ps2data_in),
    .ps2clk_oe  (ps2clk_oe),
    .ps2data_oe (ps2data_oe),
    .dbg_state  (dbg_state)
  );

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  // Driver: present a command until taken
  task automatic send_cmd(input logic [7:0] d, input bit push_frame);
    for (int i = 0; i < 100 && !tx_ready; i++) tick();
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    if (push_frame) exp_q.push_back({1'b1, ~^d, d});
  endtask

  task automatic wait_act(input int budget);
    for (int i = 0; i < budget && act_q.size() == 0; i++) tick();
  endtask

  // Device model: waits for RTS, then clocks n_edges; samples data on rising edges
  task automatic dev_frame(input int n_edges, input bit ack, input int glitch_after,
                           output logic [9:0] bits, output int t_fall);
    int n;
    bits   = '0;
    t_fall = 0;
    n = 0;
    while (!(ps2clk_oe == 1'b0 && ps2data_oe == 1'b1) && n < INH + 100) begin
      tick();
      n++;
    end
    total++;
    if (!(ps2clk_oe == 1'b0 && ps2data_oe == 1'b1)) begin
      bad++;
      $display("FAIL dev_rts: clk_oe=%0b data_oe=%0b, required 0/1", ps2clk_oe, ps2data_oe);
      return;
    end
    repeat (20) tick();
    for (int k = 1; k <= n_edges; k++) begin
      if (k == 11 && ack) dev_data_low = 1'b1;
      dev_clk_low = 1'b1;
      if (k == 1) t_fall = cyc;
      repeat (HALF) tick();
      dev_clk_low = 1'b0;
      if (k <= 10) bits[k-1] = ps2data_in;
      if (k == 11) begin
        dev_data_low = 1'b0;
        break;
      end
      if (k == glitch_after) begin
        repeat (10) tick();
        dev_clk_low = 1'b1;
        repeat (2) tick();
        dev_clk_low = 1'b0;
        repeat (HALF - 12) tick();
      end else begin
        repeat (HALF) tick();
      end
    end
  endtask

  task automatic test_reset();
    iRst_n = 1'b0;
    repeat (3) tick();
    total++;
    if (tx_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_hs: ready=%0b busy=%0b, required 1/0", tx_ready, busy);
    end
    total++;
    if (ps2clk_oe !== 1'b0 || ps2data_oe !== 1'b0) begin
      bad++;
      $display("FAIL reset_oe: clk_oe=%0b data_oe=%0b, required 0/0", ps2clk_oe, ps2data_oe);
    end
    total++;
    if (tx_done !== 1'b0 || tx_err !== 1'b0 || tx_err_code !== 2'b00) begin
      bad++;
      $display("FAIL reset_res: done=%0b err=%0b code=%b, required 0/0/00", tx_done, tx_err, tx_err_code);
    end
    iRst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_send_f4();
    logic [9:0] b, e;
    logic [3:0] a, r;
    int n;
    send_cmd(PS2_CMD_ENABLE, 1'b1);
    res_q.push_back({1'b1, 1'b0, 2'b00});
    total++;
    if (busy !== 1'b1 || tx_ready !== 1'b0) begin
      bad++;
      $display("FAIL f4_busy: busy=%0b ready=%0b, required 1/0", busy, tx_ready);
    end
    n = 0;
    while (ps2clk_oe && !ps2data_oe && n < INH + 50) begin
      n++;
      tick();
    end
    total++;
    if (n != INH) begin
      bad++;
      $display("FAIL f4_inhibit: clk held %0d cycles, required %0d", n, INH);
    end
    total++;
    if (ps2clk_oe !== 1'b1 || ps2data_oe !== 1'b1) begin
      bad++;
      $display("FAIL f4_rts: clk_oe=%0b data_oe=%0b, required 1/1", ps2clk_oe, ps2data_oe);
    end
    tick();
    total++;
    if (ps2clk_oe !== 1'b0 || ps2data_oe !== 1'b1) begin
      bad++;
      $display("FAIL f4_release: clk_oe=%0b data_oe=%0b, required 0/1", ps2clk_oe, ps2data_oe);
    end
    dev_frame(11, 1'b1, 0, b, n);
    e = exp_q.pop_front();
    total++;
    if (b !== e) begin
      bad++;
      $display("FAIL f4_bits: got %b, required %b", b, e);
    end
    wait_act(500);
    r = res_q.pop_front();
    total++;
    if (act_q.size() == 0) begin
      bad++;
      $display("FAIL f4_result: no pulse, required %b", r);
    end else begin
      a = act_q.pop_front();
      void'(act_t_q.pop_front());
      if (a !== r) begin
        bad++;
        $display("FAIL f4_result: got %b, required %b", a, r);
      end
    end
    repeat (5) tick();
    total++;
    if (act_q.size() != 0 || tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL f4_single: extra pulses=%0d ready=%0b, required 0/1", act_q.size(), tx_ready);
    end
  endtask

  task automatic test_send_ff();
    logic [9:0] b, e;
    logic [3:0] a, r;
    int tf;
    send_cmd(PS2_CMD_RESET, 1'b1);
    res_q.push_back({1'b1, 1'b0, 2'b00});
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    dev_frame(11, 1'b1, 0, b, tf);
    e = exp_q.pop_front();
    total++;
    if (b !== e) begin
      bad++;
      $display("FAIL ff_bits: got %b, required %b", b, e);
    end
    wait_act(500);
    r = res_q.pop_front();
    total++;
    if (act_q.size() == 0) begin
      bad++;
      $display("FAIL ff_result: no pulse, required %b", r);
    end else begin
      a = act_q.pop_front();
      void'(act_t_q.pop_front());
      if (a !== r) begin
        bad++;
        $display("FAIL ff_result: got %b, required %b", a, r);
      end
    end
  endtask

  task automatic test_start_timeout();
    logic [3:0] a, r;
    int n, t_rts, t_err;
    send_cmd(8'h55, 1'b0);
    res_q.push_back({1'b0, 1'b1, ERR_START});
    n = 0;
    while (!(ps2clk_oe && ps2data_oe) && n < INH + 50) begin
      tick();
      n++;
    end
    t_rts = cyc;
    n = 0;
    while (!tx_err && !tx_done && n < ST + 100) begin
      tick();
      n++;
    end
    t_err = cyc;
    total++;
    if (tx_err !== 1'b1 || t_err - t_rts != ST) begin
      bad++;
      $display("FAIL st_timing: err=%0b after %0d cycles, required 1 after %0d", tx_err, t_err - t_rts, ST);
    end
    total++;
    if (tx_err_code !== ERR_START || ps2clk_oe !== 1'b0 || ps2data_oe !== 1'b0) begin
      bad++;
      $display("FAIL st_state: code=%b oe=%0b%0b, required 01 and 00", tx_err_code, ps2clk_oe, ps2data_oe);
    end
    tick();
    total++;
    if (tx_ready !== 1'b1 || tx_err_code !== ERR_START) begin
      bad++;
      $display("FAIL st_ready: ready=%0b code=%b, required 1/01", tx_ready, tx_err_code);
    end
    wait_act(5);
    r = res_q.pop_front();
    total++;
    if (act_q.size() == 0) begin
      bad++;
      $display("FAIL st_result: no pulse, required %b", r);
    end else begin
      a = act_q.pop_front();
      void'(act_t_q.pop_front());
      if (a !== r) begin
        bad++;
        $display("FAIL st_result: got %b, required %b", a, r);
      end
    end
  endtask

  task automatic test_no_ack();
    logic [9:0] b, e;
    logic [3:0] a, r;
    int tf;
    send_cmd(8'hA7, 1'b1);
    res_q.push_back({1'b0, 1'b1, ERR_NOACK});
    dev_frame(11, 1'b0, 0, b, tf);
    e = exp_q.pop_front();
    total++;
    if (b !== e) begin
      bad++;
      $display("FAIL na_bits: got %b, required %b", b, e);
    end
    wait_act(500);
    r = res_q.pop_front();
    total++;
    if (act_q.size() == 0) begin
      bad++;
      $display("FAIL na_result: no pulse, required %b", r);
    end else begin
      a = act_q.pop_front();
      void'(act_t_q.pop_front());
      if (a !== r) begin
        bad++;
        $display("FAIL na_result: got %b, required %b", a, r);
      end
    end
  endtask

  task automatic test_xfer_timeout();
    logic [9:0] b;
    logic [3:0] a, r;
    int tf, ta;
    send_cmd(PS2_CMD_RESET, 1'b0);
    res_q.push_back({1'b0, 1'b1, ERR_XFER});
    dev_frame(4, 1'b1, 0, b, tf);
    wait_act(XF + 200);
    r = res_q.pop_front();
    total++;
    if (act_q.size() == 0) begin
      bad++;
      $display("FAIL xf_result: no pulse, required %b", r);
    end else begin
      a  = act_q.pop_front();
      ta = act_t_q.pop_front();
      if (a !== r) begin
        bad++;
        $display("FAIL xf_result: got %b, required %b", a, r);
      end
      total++;
      if (ta - tf < XF || ta - tf > XF + FL + 6) begin
        bad++;
        $display("FAIL xf_timing: err %0d cycles after first edge, required %0d..%0d", ta - tf, XF, XF + FL + 6);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] b, e;
    logic [3:0] a, r;
    int tf;
    send_cmd(PS2_CMD_ENABLE, 1'b0);
    dev_frame(2, 1'b1, 0, b, tf);
    total++;
    if (ps2data_oe !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rm_pre: data_oe=%0b busy=%0b, required 1/1", ps2data_oe, busy);
    end
    iRst_n = 1'b0;
    #1;
    total++;
    if (ps2clk_oe !== 1'b0 || ps2data_oe !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rm_async: oe=%0b%0b busy=%0b, required 00/0", ps2clk_oe, ps2data_oe, busy);
    end
    repeat (3) tick();
    iRst_n = 1'b1;
    repeat (5) tick();
    total++;
    if (act_q.size() != 0) begin
      bad++;
      $display("FAIL rm_nopulse: %0d pulses, required 0", act_q.size());
    end
    send_cmd(PS2_CMD_ENABLE, 1'b1);
    res_q.push_back({1'b1, 1'b0, 2'b00});
    dev_frame(11, 1'b1, 0, b, tf);
    e = exp_q.pop_front();
    total++;
    if (b !== e) begin
      bad++;
      $display("FAIL rm_bits: got %b, required %b", b, e);
    end
    wait_act(500);
    r = res_q.pop_front();
    total++;
    if (act_q.size() == 0) begin
      bad++;
      $display("FAIL rm_result: no pulse, required %b", r);
    end else begin
      a = act_q.pop_front();
      void'(act_t_q.pop_front());
      if (a !== r) begin
        bad++;
        $display("FAIL rm_result: got %b, required %b", a, r);
      end
    end
  endtask

  task automatic test_glitch();
    logic [9:0] b, e;
    logic [3:0] a, r;
    int tf;
    send_cmd(8'h3C, 1'b1);
    res_q.push_back({1'b1, 1'b0, 2'b00});
    dev_frame(11, 1'b1, 3, b, tf);
    e = exp_q.pop_front();
    total++;
    if (b !== e) begin
      bad++;
      $display("FAIL gl_bits: got %b, required %b", b, e);
    end
    wait_act(500);
    r = res_q.pop_front();
    total++;
    if (act_q.size() == 0) begin
      bad++;
      $display("FAIL gl_result: no pulse, required %b", r);
    end else begin
      a = act_q.pop_front();
      void'(act_t_q.pop_front());
      if (a !== r) begin
        bad++;
        $display("FAIL gl_result: got %b, required %b", a, r);
      end
    end
  endtask

  // Watchdog
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_send_f4();
    test_send_ff();
    test_start_timeout();
    test_no_ack();
    test_xfer_timeout();
    test_reset_mid();
    test_glitch();
    repeat (5) tick();
    total++;
    if (done_cnt != 4 || err_cnt != 3) begin
      bad++;
      $display("FAIL pulse_count: done=%0d err=%0d, required 4/3", done_cnt, err_cnt);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
